// File: rtl/cpu_phase_sequencer_if.sv
// Control, decoder and shared memory-port signals of the phase sequencer.
// The sequencer takes the master view; the surrounding core/memory takes the slave view.
interface cpu_phase_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             step_mode;
    logic             is_halt;
    logic             is_mem;
    logic             mem_wr;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             ir_we;
    logic             commit;
    logic [4:0]       phase;
    logic             running;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, stop, step_mode, is_halt, is_mem, mem_wr, mem_ack,
        output mem_req, mem_we, ir_we, commit, phase, running, halted, fault, instr_count
    );

    modport slave (
        output start, stop, step_mode, is_halt, is_mem, mem_wr, mem_ack,
        input  mem_req, mem_we, ir_we, commit, phase, running, halted, fault, instr_count
    );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the 16-bit core; owns the shared memory port,
// the run/stop/step control and a memory-wait watchdog.
module cpu_phase_sequencer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   rst_n,
    cpu_phase_sequencer_if.master io_seq
);
    localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit WdogEn = (MEM_TIMEOUT != 0);
    localparam logic [WaitW-1:0] WaitLast = WdogEn ? WaitW'(MEM_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        StIdle,
        StIf,
        StId,
        StEx,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_stop;
    logic             w_stop_nxt;
    logic [WaitW-1:0] r_wait;
    logic [WaitW-1:0] w_wait_nxt;
    logic             r_fault;
    logic             w_fault_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    logic             w_mem_phase;
    logic             w_run_state;
    logic             w_timeout;
    logic             w_stop_pend;
    logic             w_mem_req;
    logic             w_mem_we;
    logic             w_ir_we;
    logic             w_commit;
    logic [4:0]       w_phase;
    logic             w_running;
    logic             w_halted;

    assign w_mem_phase = (r_state == StIf) || (r_state == StMem);
    assign w_run_state = (r_state != StIdle) && (r_state != StHalt);
    assign w_timeout   = WdogEn && w_mem_phase && !io_seq.mem_ack && (r_wait == WaitLast);
    // A stop seen during WB itself still ends execution at this boundary.
    assign w_stop_pend = r_stop || io_seq.stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_stop  <= 1'b0;
            r_wait  <= '0;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stop  <= w_stop_nxt;
            r_wait  <= w_wait_nxt;
            r_fault <= w_fault_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (io_seq.start && !io_seq.stop) begin
                    w_state_nxt = StIf;
                end
            end
            StIf: begin
                if (io_seq.mem_ack) begin
                    w_state_nxt = StId;
                end else if (w_timeout) begin
                    w_state_nxt = StHalt;
                end
            end
            StId: w_state_nxt = StEx;
            StEx: begin
                if (io_seq.is_halt) begin
                    w_state_nxt = StHalt;
                end else if (io_seq.is_mem) begin
                    w_state_nxt = StMem;
                end else begin
                    w_state_nxt = StWb;
                end
            end
            StMem: begin
                if (io_seq.mem_ack) begin
                    w_state_nxt = StWb;
                end else if (w_timeout) begin
                    w_state_nxt = StHalt;
                end
            end
            StWb: begin
                if (w_stop_pend || io_seq.step_mode) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_state_nxt = StIf;
                end
            end
            StHalt:  w_state_nxt = StHalt;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_stop_nxt  = r_stop;
        w_wait_nxt  = r_wait;
        w_fault_nxt = r_fault;
        w_count_nxt = r_count;

        if (w_state_nxt == StIdle) begin
            w_stop_nxt = 1'b0;
        end else if (w_run_state && io_seq.stop) begin
            w_stop_nxt = 1'b1;
        end

        // Each memory request gets a fresh wait budget.
        if (((w_state_nxt == StIf) && (r_state != StIf)) ||
            ((w_state_nxt == StMem) && (r_state != StMem))) begin
            w_wait_nxt = '0;
        end else if (w_mem_phase && !io_seq.mem_ack) begin
            w_wait_nxt = r_wait + 1'b1;
        end

        if (w_timeout) begin
            w_fault_nxt = 1'b1;
        end

        if (r_state == StWb) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_comb begin
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        w_ir_we   = 1'b0;
        w_commit  = 1'b0;
        w_phase   = 5'b00000;
        w_running = 1'b1;
        w_halted  = 1'b0;
        unique case (r_state)
            StIdle: w_running = 1'b0;
            StIf: begin
                w_phase   = 5'b00001;
                w_mem_req = 1'b1;
                w_ir_we   = io_seq.mem_ack;
            end
            StId: w_phase = 5'b00010;
            StEx: w_phase = 5'b00100;
            StMem: begin
                w_phase   = 5'b01000;
                w_mem_req = 1'b1;
                w_mem_we  = io_seq.mem_wr;
            end
            StWb: begin
                w_phase  = 5'b10000;
                w_commit = 1'b1;
            end
            StHalt: begin
                w_running = 1'b0;
                w_halted  = 1'b1;
            end
            default: w_running = 1'b0;
        endcase
    end

    assign io_seq.mem_req     = w_mem_req;
    assign io_seq.mem_we      = w_mem_we;
    assign io_seq.ir_we       = w_ir_we;
    assign io_seq.commit      = w_commit;
    assign io_seq.phase       = w_phase;
    assign io_seq.running     = w_running;
    assign io_seq.halted      = w_halted;
    assign io_seq.fault       = r_fault;
    assign io_seq.instr_count = r_count;

    a_phase_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_phase));
    a_we_needs_req: assert property (@(posedge clk) disable iff (!rst_n) w_mem_we |-> w_mem_req);
    a_ir_we_in_if:  assert property (@(posedge clk) disable iff (!rst_n)
                                     w_ir_we |-> (r_state == StIf));
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Self-checking bench for cpu_phase_sequencer: programs of instructions are expanded by a
// behavioural model into per-cycle input/expected-output traces and replayed against the DUT.
module tb_cpu_phase_sequencer;
    localparam int unsigned CntW = 16;
    localparam int Timeout = 4;
    localparam int VecW = CntW + 12;
    localparam int KAlu = 0;
    localparam int KLd  = 1;
    localparam int KSt  = 2;
    localparam int KHlt = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cpu_phase_sequencer_if #(.CNT_W(CntW)) bus ();

    cpu_phase_sequencer #(
        .CNT_W      (CntW),
        .MEM_TIMEOUT(Timeout)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_seq(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit              start, stop, step, is_halt, is_mem, mem_wr, ack;
        logic [4:0]      phase;
        bit              req, we, irwe, commit, halted, fault;
        logic [CntW-1:0] count;
    } cyc_t;

    // wf/wm: wait cycles before ack in IF/MEM; stop_ph: 0 none, 1 IF, 2 ID, 3 EX, 4 MEM
    typedef struct {
        int kind;
        int wf;
        int wm;
        int stop_ph;
        int gap;
    } instr_t;

    instr_t          prog_q[$];
    cyc_t            exp_q[$];
    logic [CntW-1:0] cnt_m;
    bit              fault_m;

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t rnd_cyc(logic [4:0] ph);
        cyc_t c;
        c.start   = rb();
        c.stop    = 1'b0;
        c.step    = rb();
        c.is_halt = rb();
        c.is_mem  = rb();
        c.mem_wr  = rb();
        c.ack     = rb();
        c.phase   = ph;
        c.req     = 1'b0;
        c.we      = 1'b0;
        c.irwe    = 1'b0;
        c.commit  = 1'b0;
        c.halted  = 1'b0;
        c.fault   = 1'b0;
        c.count   = cnt_m;
        return c;
    endfunction

    function automatic void add_instr(int kind, int wf, int wm, int stop_ph, int gap);
        instr_t t;
        t.kind    = kind;
        t.wf      = wf;
        t.wm      = wm;
        t.stop_ph = stop_ph;
        t.gap     = gap;
        prog_q.push_back(t);
    endfunction

    // Expand prog_q into the cycle trace the sequencer must produce from IDLE after reset.
    function automatic void build_expected(bit step);
        cyc_t c;
        bit   idle;
        bit   done;
        int   nreq;
        exp_q.delete();
        cnt_m   = '0;
        fault_m = 1'b0;
        idle    = 1'b1;
        done    = 1'b0;
        for (int i = 0; i < prog_q.size() && !done; i++) begin
            instr_t t;
            t = prog_q[i];
            if (idle) begin
                for (int g = 0; g < t.gap; g++) begin
                    c = rnd_cyc(5'b00000);
                    c.stop = rb();
                    if (!c.stop) c.start = 1'b0;
                    exp_q.push_back(c);
                end
                c = rnd_cyc(5'b00000);
                c.start = 1'b1;
                exp_q.push_back(c);
                idle = 1'b0;
            end
            nreq = (t.wf >= Timeout) ? Timeout : t.wf + 1;
            for (int k = 0; k < nreq; k++) begin
                c = rnd_cyc(5'b00001);
                c.req  = 1'b1;
                c.ack  = (t.wf < Timeout) && (k == t.wf);
                c.irwe = c.ack;
                c.stop = (t.stop_ph == 1) && (k == 0);
                exp_q.push_back(c);
            end
            if (t.wf >= Timeout) begin
                fault_m = 1'b1;
                done    = 1'b1;
            end else begin
                c = rnd_cyc(5'b00010);
                c.stop = (t.stop_ph == 2);
                exp_q.push_back(c);
                c = rnd_cyc(5'b00100);
                c.is_halt = (t.kind == KHlt);
                c.is_mem  = (t.kind == KLd) || (t.kind == KSt);
                c.stop    = (t.stop_ph == 3);
                exp_q.push_back(c);
                if (t.kind == KHlt) begin
                    done = 1'b1;
                end else begin
                    if (t.kind != KAlu) begin
                        nreq = (t.wm >= Timeout) ? Timeout : t.wm + 1;
                        for (int k = 0; k < nreq; k++) begin
                            c = rnd_cyc(5'b01000);
                            c.req    = 1'b1;
                            c.mem_wr = (t.kind == KSt);
                            c.we     = c.mem_wr;
                            c.ack    = (t.wm < Timeout) && (k == t.wm);
                            c.stop   = (t.stop_ph == 4) && (k == 0);
                            exp_q.push_back(c);
                        end
                        if (t.wm >= Timeout) begin
                            fault_m = 1'b1;
                            done    = 1'b1;
                        end
                    end
                    if (!done) begin
                        c = rnd_cyc(5'b10000);
                        c.commit = 1'b1;
                        c.step   = step;
                        exp_q.push_back(c);
                        cnt_m = cnt_m + 1'b1;
                        if (step || (t.stop_ph != 0)) idle = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            c = rnd_cyc(5'b00000);
            c.stop   = rb();
            c.halted = 1'b1;
            c.fault  = fault_m;
            exp_q.push_back(c);
        end
    endfunction

    function automatic logic [VecW-1:0] exp_vec(cyc_t c);
        return {c.phase, c.req, c.we, c.irwe, c.commit, |c.phase, c.halted, c.fault, c.count};
    endfunction

    function automatic logic [VecW-1:0] obs_vec();
        return {bus.phase, bus.mem_req, bus.mem_we, bus.ir_we, bus.commit, bus.running,
                bus.halted, bus.fault, bus.instr_count};
    endfunction

    task automatic drive_cyc(cyc_t c);
        bus.start     = c.start;
        bus.stop      = c.stop;
        bus.step_mode = c.step;
        bus.is_halt   = c.is_halt;
        bus.is_mem    = c.is_mem;
        bus.mem_wr    = c.mem_wr;
        bus.mem_ack   = c.ack;
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.step_mode = 1'b0;
        bus.is_halt   = 1'b0;
        bus.is_mem    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prog_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.start = 1'b1;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs_vec(), {VecW{1'b0}});
        end
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== '0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", k, obs_vec(), {VecW{1'b0}});
            end
        end
        next_edge();
    endtask

    task automatic test_alu_sequence();
        apply_reset();
        for (int i = 0; i < 3; i++) add_instr(KAlu, 0, 0, 0, 0);
        add_instr(KHlt, 0, 0, 0, 0);
        build_expected(1'b0);
        foreach (exp_q[k]) begin
            drive_cyc(exp_q[k]);
            checks++;
            if (obs_vec() !== exp_vec(exp_q[k])) begin
                failures++;
                $display("FAIL alu_sequence cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec(exp_q[k]));
            end
            next_edge();
        end
    endtask

    task automatic test_ld_wait();
        apply_reset();
        add_instr(KLd, 0, 2, 0, 0);
        add_instr(KAlu, 1, 0, 0, 0);
        add_instr(KHlt, 0, 0, 0, 0);
        build_expected(1'b0);
        foreach (exp_q[k]) begin
            drive_cyc(exp_q[k]);
            checks++;
            if (obs_vec() !== exp_vec(exp_q[k])) begin
                failures++;
                $display("FAIL ld_wait cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec(exp_q[k]));
            end
            next_edge();
        end
    endtask

    task automatic test_st();
        apply_reset();
        add_instr(KSt, 1, 1, 0, 0);
        add_instr(KSt, 0, 0, 0, 0);
        add_instr(KHlt, 2, 0, 0, 0);
        build_expected(1'b0);
        foreach (exp_q[k]) begin
            drive_cyc(exp_q[k]);
            checks++;
            if (obs_vec() !== exp_vec(exp_q[k])) begin
                failures++;
                $display("FAIL st cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec(exp_q[k]));
            end
            next_edge();
        end
    endtask

    task automatic test_halt();
        apply_reset();
        add_instr(KAlu, 0, 0, 0, 0);
        add_instr(KHlt, 0, 0, 0, 0);
        build_expected(1'b0);
        foreach (exp_q[k]) begin
            drive_cyc(exp_q[k]);
            checks++;
            if (obs_vec() !== exp_vec(exp_q[k])) begin
                failures++;
                $display("FAIL halt cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec(exp_q[k]));
            end
            next_edge();
        end
    endtask

    task automatic test_step_mode();
        apply_reset();
        add_instr(KAlu, 0, 0, 0, 0);
        add_instr(KLd, 1, 0, 0, 2);
        add_instr(KSt, 0, 1, 0, 1);
        add_instr(KHlt, 0, 0, 0, 1);
        build_expected(1'b1);
        foreach (exp_q[k]) begin
            drive_cyc(exp_q[k]);
            checks++;
            if (obs_vec() !== exp_vec(exp_q[k])) begin
                failures++;
                $display("FAIL step_mode cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec(exp_q[k]));
            end
            next_edge();
        end
    endtask

    task automatic test_stop();
        apply_reset();
        add_instr(KAlu, 0, 0, 2, 0);
        add_instr(KAlu, 0, 0, 0, 2);
        add_instr(KLd, 0, 1, 4, 0);
        add_instr(KAlu, 0, 0, 0, 1);
        add_instr(KHlt, 0, 0, 0, 0);
        build_expected(1'b0);
        foreach (exp_q[k]) begin
            drive_cyc(exp_q[k]);
            checks++;
            if (obs_vec() !== exp_vec(exp_q[k])) begin
                failures++;
                $display("FAIL stop cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec(exp_q[k]));
            end
            next_edge();
        end
    endtask

    task automatic test_watchdog();
        for (int s = 0; s < 3; s++) begin
            apply_reset();
            case (s)
                0: add_instr(KAlu, 4, 0, 0, 0);
                1: begin
                    add_instr(KAlu, 3, 0, 0, 0);
                    add_instr(KHlt, 0, 0, 0, 0);
                end
                default: begin
                    add_instr(KAlu, 0, 0, 0, 0);
                    add_instr(KLd, 0, 5, 0, 0);
                end
            endcase
            build_expected(1'b0);
            foreach (exp_q[k]) begin
                drive_cyc(exp_q[k]);
                checks++;
                if (obs_vec() !== exp_vec(exp_q[k])) begin
                    failures++;
                    $display("FAIL watchdog s=%0d cyc=%0d got=%h exp=%h", s, k, obs_vec(),
                             exp_vec(exp_q[k]));
                end
                next_edge();
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        bus.start = 1'b1;
        next_edge();
        bus.start = 1'b0;
        next_edge();
        checks++;
        if ({bus.phase, bus.mem_req} !== {5'b00001, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_if_pre got=%b exp=%b", {bus.phase, bus.mem_req}, 6'b000011);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_mid_if got=%h exp=%h", obs_vec(), {VecW{1'b0}});
        end

        apply_reset();
        bus.start = 1'b1;
        next_edge();
        bus.start   = 1'b0;
        bus.mem_ack = 1'b1;
        next_edge();
        bus.mem_ack = 1'b0;
        next_edge();
        bus.is_mem = 1'b1;
        bus.mem_wr = 1'b1;
        next_edge();
        checks++;
        if ({bus.phase, bus.mem_req, bus.mem_we} !== {5'b01000, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_mem_pre got=%b exp=%b", {bus.phase, bus.mem_req, bus.mem_we},
                     7'b0100011);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_mid_mem got=%h exp=%h", obs_vec(), {VecW{1'b0}});
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 25; p++) begin
            int n;
            apply_reset();
            n = int'($urandom_range(3, 8));
            for (int i = 0; i < n; i++) begin
                int kind;
                int wf;
                int wm;
                int sp;
                kind = (i == n - 1) ? KHlt : int'($urandom_range(0, 2));
                wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6))
                                                 : int'($urandom_range(0, 3));
                wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6))
                                                 : int'($urandom_range(0, 3));
                sp = 0;
                if ($urandom_range(0, 3) == 0) begin
                    sp = int'($urandom_range(1, (kind == KLd || kind == KSt) ? 4 : 3));
                end
                add_instr(kind, wf, wm, sp, int'($urandom_range(0, 2)));
            end
            build_expected(rb());
            foreach (exp_q[k]) begin
                drive_cyc(exp_q[k]);
                checks++;
                if (obs_vec() !== exp_vec(exp_q[k])) begin
                    failures++;
                    $display("FAIL random p=%0d cyc=%0d got=%h exp=%h", p, k, obs_vec(),
                             exp_vec(exp_q[k]));
                end
                next_edge();
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_sequence();
        test_ld_wait();
        test_st();
        test_halt();
        test_step_mode();
        test_stop();
        test_watchdog();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
